kfmmc_multi_drive_mux: RTL and testbench
========================================

// Module: kfmmc_multi_drive_mux
// PURPOSE
// - N-channel front end between the host internal bus and NUM_DRIVES independent KFMMC drive instances.
// - Captures the host block address in shadow registers.
// - Commits the address plus the access command to the selected drive in one atomic burst.
// - Routes data reads and writes, aggregates per-drive interrupts into sticky, maskable status.
// - Sits between the bus decoder and the drive array; each drive keeps its own MMC pins.
// PARAMETERS
// NUM_DRIVES   2                      number of attached drives, 1..8
// SEL_WIDTH    $clog2(NUM_DRIVES)+1   width of the select register (extra bit keeps NUM_DRIVES=1 legal)
// PORTS
// clock                      in   1            system clock
// reset                      in   1            synchronous, active-high
// internal_data_bus          in   8            host write data
// write_drive_select         in   1            strobe: select <= bus[SEL_WIDTH-1:0]
// write_block_address_1..4   in   1 each       strobes: shadow address byte 1..4 <= bus
// write_access_command       in   1            strobe: start commit burst with command byte = bus
// write_data                 in   1            strobe: forward one data byte to the selected drive
// read_data                  in   1            strobe: pop one byte from the selected drive
// write_interrupt_mask       in   1            strobe: mask <= bus (bit i = drive i)
// write_interrupt_clear      in   1            strobe: pending bits written 1 are cleared
// read_data_byte             out  8            read_data_byte of the selected drive (combinational mux)
// status                     out  8            {busy_any, rejected, commit_busy, 0, sel[3:0]}
// interrupt_pending          out  8            sticky per-drive pending bits, zero-extended
// interrupt                  out  1            |(pending & ~mask), registered
// drv_data_bus               out  8            fan-out bus to all drives
// drv_write_block_address_1..4 out NUM_DRIVES  one-hot strobes
// drv_write_access_command   out  NUM_DRIVES   one-hot strobe
// drv_write_data             out  NUM_DRIVES   one-hot strobe
// drv_read_data              out  NUM_DRIVES   one-hot strobe
// drv_read_data_byte         in   8*NUM_DRIVES per-drive read bytes, drive i at [8i+7:8i]
// drv_busy                   in   NUM_DRIVES   per-drive drive_busy
// drv_read_interface_error   in   NUM_DRIVES   per-drive flag
// drv_read_crc_error         in   NUM_DRIVES   per-drive flag
// drv_block_read_interrupt   in   NUM_DRIVES   per-drive pulse
// drv_read_completion_interrupt in NUM_DRIVES  per-drive pulse
// BEHAVIOUR
// - Reset:
//   - sel=0, shadow address=0, command latch=0, mask=8'hFF, pending=0, rejected=0.
//   - FSM=IDLE; all drv_* strobes 0; interrupt=0.
// - Address writes update only the shadow registers; no drive sees them until a commit.
// - Commit FSM: IDLE -> A1 -> A2 -> A3 -> A4 -> CMD -> IDLE, one cycle per state.
//   - A1..A4 each emit the matching one-hot address strobe with its shadow byte on drv_data_bus.
//   - CMD emits drv_write_access_command with the latched command byte.
//   - Total 5 cycles; commit_busy=1 from the cycle after the strobe through the CMD cycle.
// - Rejection: write_access_command while drv_busy[sel]=1, or while commit_busy=1, is dropped.
//   - Dropping sets sticky rejected; no strobes are emitted.
//   - rejected clears on the next accepted command or on write_interrupt_clear with bus[7]=1.
// - Select:
//   - Values >= NUM_DRIVES are ignored (sel holds).
//   - write_drive_select during commit_busy is held and applied when the FSM returns to IDLE.
//   - The commit always targets the drive selected when the command was accepted.
// - Passthrough:
//   - write_data and read_data produce a same-cycle one-hot strobe to drive sel, driving bus data.
//   - During commit_busy these strobes are dropped and rejected is set.
// - Interrupts:
//   - pending[i] <= pending[i] | block_read[i] | completion[i] | rising edge of (if_err[i] | crc_err[i]).
//   - When a set and a clear of the same bit hit the same cycle, set wins.
//   - interrupt is updated 1 cycle after pending.
// - busy_any = |drv_busy | commit_busy.
// - Synchronous reset mid-burst: the FSM returns to IDLE immediately and no further strobes are emitted.
// STRUCTURE
// - Package kfmmc_mux_pkg: commit_state_t enum (IDLE,A1,A2,A3,A4,CMD); MAX_DRIVES=8; status bit-index localparams.
// - Sub-module kfmmc_irq_collector: pending, mask, edge detect and interrupt for NUM_DRIVES.
// - Commit FSM, select logic and routing stay in the top level.
// TESTING
// - Address 0x12,0x34,0x56,0x78, command 0x11 to drive 1:
//   - strobes on drive 1 only, bus values 12,34,56,78,11 on 5 consecutive cycles.
//   - commit_busy is high for exactly 5 cycles.
// - Command with drv_busy[0]=1, sel=0: no strobes; status[6]=1; the next accepted command clears it.
// - write_drive_select=1 issued in cycle 2 of the burst: the burst completes on drive 0; sel reads 1 only after IDLE.
// - Select value 5 with NUM_DRIVES=2: sel is unchanged.
// - Interrupts with mask=8'hFE:
//   - block_read pulse on drive 0: pending=8'h01 and interrupt=1 on the next cycle.
//   - Clear 0x01 coincident with a new pulse: pending stays 1.
// - Reset asserted during state A3: no access_command strobe ever fires; all outputs return to reset values.

Source files
------------

// File: rtl/kfmmc_mux_pkg.sv
// Purpose: shared types and constants for the KFMMC multi-drive front end.
// Latency: none; this file holds only types, constants and a pure function.
// Backpressure: none.
package kfmmc_mux_pkg;

    // Upper bound on attached drives. The mask and pending registers are
    // byte-wide at the host interface.
    localparam int MAX_DRIVES = 8;

    // Bit positions inside the host-visible status byte.
    localparam int STAT_BUSY_ANY    = 7;
    localparam int STAT_REJECTED    = 6;
    localparam int STAT_COMMIT_BUSY = 5;
    localparam int STAT_SEL_MSB     = 3;

    // Commit burst: four address bytes followed by the command byte.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A1   = 3'd1,
        A2   = 3'd2,
        A3   = 3'd3,
        A4   = 3'd4,
        CMD  = 3'd5
    } commit_state_t;

    // Successor of a burst state. IDLE only leaves on an accepted command,
    // so the top level handles that case itself.
    function automatic commit_state_t commit_next(input commit_state_t s);
        case (s)
            A1:      return A2;
            A2:      return A3;
            A3:      return A4;
            A4:      return CMD;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/kfmmc_irq_collector.sv
// Purpose: sticky per-drive interrupt pending bits, mask, and the combined interrupt line.
// Latency: pending updates 1 cycle after an event; interrupt follows pending by 1 more cycle.
// Backpressure: none; events are never lost, and a set wins over a same-cycle clear.
//
// Ports:
//   clock_i, reset_i          clock and synchronous active-high reset
//   block_read_i              per-drive block-read pulse
//   completion_i              per-drive read-completion pulse
//   err_i                     per-drive error level (interface | CRC); rising edge sets pending
//   mask_wr_i / mask_dat_i    mask write strobe and data (bit i = 1 masks drive i)
//   clr_wr_i / clr_dat_i      clear strobe and data (bit i = 1 clears pending i)
//   pending_o                 sticky pending bits
//   interrupt_o               registered OR of the unmasked pending bits
module kfmmc_irq_collector #(
    parameter int NUM_DRIVES = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_DRIVES-1:0] block_read_i,
    input  logic [NUM_DRIVES-1:0] completion_i,
    input  logic [NUM_DRIVES-1:0] err_i,
    input  logic                  mask_wr_i,
    input  logic [NUM_DRIVES-1:0] mask_dat_i,
    input  logic                  clr_wr_i,
    input  logic [NUM_DRIVES-1:0] clr_dat_i,
    output logic [NUM_DRIVES-1:0] pending_o,
    output logic                  interrupt_o
);

    logic [NUM_DRIVES-1:0] pending_q, pending_d;
    logic [NUM_DRIVES-1:0] mask_q, mask_d;
    logic [NUM_DRIVES-1:0] err_q;
    logic [NUM_DRIVES-1:0] clr_bits;
    logic                  irq_q;

    always_comb begin
        clr_bits  = clr_wr_i ? clr_dat_i : '0;
        // Clear is applied first so that a same-cycle event re-sets the bit.
        pending_d = (pending_q & ~clr_bits)
                  | block_read_i
                  | completion_i
                  | (err_i & ~err_q);
        mask_d    = mask_wr_i ? mask_dat_i : mask_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pending_q <= '0;
            mask_q    <= '1;
            err_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            err_q     <= err_i;
            // Sampled from the registered pending bits, so the line trails them by a cycle.
            irq_q     <= |(pending_q & ~mask_q);
        end
    end

    assign pending_o   = pending_q;
    assign interrupt_o = irq_q;

endmodule

// File: rtl/kfmmc_multi_drive_mux.sv
// Purpose: host-bus front end fanning out to NUM_DRIVES KFMMC drives. It holds the shadowed
//          block address, runs the atomic commit burst, passes data through, and collects interrupts.
// Latency: the commit burst occupies the 5 cycles after the accepted command. Data strobes
//          and read_data_byte are combinational in the same cycle.
// Backpressure: none. A command, data read or data write that cannot be served is dropped
//          and flags the sticky rejected bit.
//
// Ports:
//   clock_i, reset_i                      clock and synchronous active-high reset
//   internal_data_bus_i                   host write data
//   write_* / read_data_i                 host strobes: select, address bytes 1..4, command,
//                                         data write, data read, irq mask, irq clear
//   read_data_byte_o                      byte from the selected drive
//   status_o                              {busy_any, rejected, commit_busy, 0, sel[3:0]}
//   interrupt_pending_o / interrupt_o     sticky pending bits and the combined interrupt
//   drv_data_bus_o, drv_write_*_o,
//   drv_read_data_o                       shared data bus and one-hot per-drive strobes
//   drv_*_i                               per-drive read bytes, busy, error and interrupt inputs
module kfmmc_multi_drive_mux
    import kfmmc_mux_pkg::*;
#(
    parameter int NUM_DRIVES = 2,
    parameter int SEL_WIDTH  = $clog2(NUM_DRIVES) + 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [7:0]              internal_data_bus_i,
    input  logic                    write_drive_select_i,
    input  logic                    write_block_address_1_i,
    input  logic                    write_block_address_2_i,
    input  logic                    write_block_address_3_i,
    input  logic                    write_block_address_4_i,
    input  logic                    write_access_command_i,
    input  logic                    write_data_i,
    input  logic                    read_data_i,
    input  logic                    write_interrupt_mask_i,
    input  logic                    write_interrupt_clear_i,
    output logic [7:0]              read_data_byte_o,
    output logic [7:0]              status_o,
    output logic [7:0]              interrupt_pending_o,
    output logic                    interrupt_o,
    output logic [7:0]              drv_data_bus_o,
    output logic [NUM_DRIVES-1:0]   drv_write_block_address_1_o,
    output logic [NUM_DRIVES-1:0]   drv_write_block_address_2_o,
    output logic [NUM_DRIVES-1:0]   drv_write_block_address_3_o,
    output logic [NUM_DRIVES-1:0]   drv_write_block_address_4_o,
    output logic [NUM_DRIVES-1:0]   drv_write_access_command_o,
    output logic [NUM_DRIVES-1:0]   drv_write_data_o,
    output logic [NUM_DRIVES-1:0]   drv_read_data_o,
    input  logic [8*NUM_DRIVES-1:0] drv_read_data_byte_i,
    input  logic [NUM_DRIVES-1:0]   drv_busy_i,
    input  logic [NUM_DRIVES-1:0]   drv_read_interface_error_i,
    input  logic [NUM_DRIVES-1:0]   drv_read_crc_error_i,
    input  logic [NUM_DRIVES-1:0]   drv_block_read_interrupt_i,
    input  logic [NUM_DRIVES-1:0]   drv_read_completion_interrupt_i
);

    commit_state_t         state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [SEL_WIDTH-1:0]  psel_q, psel_d;       // select written mid-burst, applied at burst end
    logic                  psel_vld_q, psel_vld_d;
    logic [3:0][7:0]       shadow_q, shadow_d;   // host-visible address bytes
    logic [3:0][7:0]       burst_q, burst_d;     // snapshot used by the running burst
    logic [7:0]            cmd_q, cmd_d;
    logic [NUM_DRIVES-1:0] tgt_q, tgt_d;         // one-hot target frozen at acceptance
    logic                  rejected_q, rejected_d;

    logic [NUM_DRIVES-1:0] sel_oh;
    logic [SEL_WIDTH-1:0]  sel_val;
    logic                  sel_wr_ok;
    logic                  commit_busy;
    logic                  busy_sel;
    logic                  cmd_accept;
    logic                  cmd_drop;
    logic                  pass_drop;
    logic [NUM_DRIVES-1:0] irq_pending;

    // One-hot decode of sel_q. This avoids indexing narrow vectors with a wider select.
    always_comb begin
        for (int i = 0; i < NUM_DRIVES; i++) begin
            sel_oh[i] = (sel_q == SEL_WIDTH'(i));
        end
    end

    assign sel_val     = internal_data_bus_i[SEL_WIDTH-1:0];
    // The whole byte is range-checked, so high bits cannot alias onto a legal drive.
    assign sel_wr_ok   = write_drive_select_i && (internal_data_bus_i < 8'(NUM_DRIVES));
    assign commit_busy = (state_q != IDLE);
    assign busy_sel    = |(drv_busy_i & sel_oh);
    assign cmd_accept  = write_access_command_i && !commit_busy && !busy_sel;
    assign cmd_drop    = write_access_command_i && !cmd_accept;
    assign pass_drop   = (write_data_i || read_data_i) && commit_busy;

    // Next-state for the host-facing registers.
    always_comb begin
        shadow_d = shadow_q;
        if (write_block_address_1_i) shadow_d[0] = internal_data_bus_i;
        if (write_block_address_2_i) shadow_d[1] = internal_data_bus_i;
        if (write_block_address_3_i) shadow_d[2] = internal_data_bus_i;
        if (write_block_address_4_i) shadow_d[3] = internal_data_bus_i;

        burst_d = cmd_accept ? shadow_q : burst_q;
        cmd_d   = cmd_accept ? internal_data_bus_i : cmd_q;
        tgt_d   = cmd_accept ? sel_oh : tgt_q;

        // Selection cannot move while a burst is in flight. A request made during
        // the burst is parked and lands as the FSM leaves CMD.
        sel_d      = sel_q;
        psel_d     = psel_q;
        psel_vld_d = psel_vld_q;
        if (state_q == CMD) begin
            psel_vld_d = 1'b0;
            if (psel_vld_q) sel_d = psel_q;
        end
        if (sel_wr_ok) begin
            if (commit_busy && state_q != CMD) begin
                psel_d     = sel_val;
                psel_vld_d = 1'b1;
            end else begin
                sel_d = sel_val;
            end
        end

        // A drop in the same cycle as a clear leaves the flag set.
        rejected_d = rejected_q;
        if (write_interrupt_clear_i && internal_data_bus_i[7]) rejected_d = 1'b0;
        if (cmd_accept)                                        rejected_d = 1'b0;
        if (cmd_drop || pass_drop)                             rejected_d = 1'b1;
    end

    // Commit FSM next-state and all drive-side outputs.
    always_comb begin
        state_d                     = state_q;
        drv_data_bus_o              = internal_data_bus_i;
        drv_write_block_address_1_o = '0;
        drv_write_block_address_2_o = '0;
        drv_write_block_address_3_o = '0;
        drv_write_block_address_4_o = '0;
        drv_write_access_command_o  = '0;
        drv_write_data_o            = '0;
        drv_read_data_o             = '0;

        case (state_q)
            IDLE: begin
                if (cmd_accept) state_d = A1;
            end
            A1: begin
                state_d                     = commit_next(state_q);
                drv_data_bus_o              = burst_q[0];
                drv_write_block_address_1_o = tgt_q;
            end
            A2: begin
                state_d                     = commit_next(state_q);
                drv_data_bus_o              = burst_q[1];
                drv_write_block_address_2_o = tgt_q;
            end
            A3: begin
                state_d                     = commit_next(state_q);
                drv_data_bus_o              = burst_q[2];
                drv_write_block_address_3_o = tgt_q;
            end
            A4: begin
                state_d                     = commit_next(state_q);
                drv_data_bus_o              = burst_q[3];
                drv_write_block_address_4_o = tgt_q;
            end
            CMD: begin
                state_d                    = commit_next(state_q);
                drv_data_bus_o             = cmd_q;
                drv_write_access_command_o = tgt_q;
            end
            default: state_d = IDLE;
        endcase

        // Passthrough owns the drive bus only while no burst is using it.
        if (!commit_busy) begin
            if (write_data_i) drv_write_data_o = sel_oh;
            if (read_data_i)  drv_read_data_o  = sel_oh;
        end

        // Reset blanks the strobes in the cycle it is asserted. A burst cut off
        // mid-flight therefore never emits another strobe.
        if (reset_i) begin
            drv_data_bus_o              = internal_data_bus_i;
            drv_write_block_address_1_o = '0;
            drv_write_block_address_2_o = '0;
            drv_write_block_address_3_o = '0;
            drv_write_block_address_4_o = '0;
            drv_write_access_command_o  = '0;
            drv_write_data_o            = '0;
            drv_read_data_o             = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            psel_q     <= '0;
            psel_vld_q <= 1'b0;
            shadow_q   <= '0;
            burst_q    <= '0;
            cmd_q      <= '0;
            tgt_q      <= '0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            psel_q     <= psel_d;
            psel_vld_q <= psel_vld_d;
            shadow_q   <= shadow_d;
            burst_q    <= burst_d;
            cmd_q      <= cmd_d;
            tgt_q      <= tgt_d;
            rejected_q <= rejected_d;
        end
    end

    // Read mux for the selected drive's byte.
    always_comb begin
        read_data_byte_o = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (sel_oh[i]) read_data_byte_o = drv_read_data_byte_i[8*i +: 8];
        end
    end

    always_comb begin
        status_o                     = '0;
        status_o[STAT_BUSY_ANY]      = (|drv_busy_i) | commit_busy;
        status_o[STAT_REJECTED]      = rejected_q;
        status_o[STAT_COMMIT_BUSY]   = commit_busy;
        status_o[STAT_SEL_MSB:0]     = 4'(sel_q);
    end

    kfmmc_irq_collector #(
        .NUM_DRIVES (NUM_DRIVES)
    ) u_irq (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .block_read_i (drv_block_read_interrupt_i),
        .completion_i (drv_read_completion_interrupt_i),
        .err_i        (drv_read_interface_error_i | drv_read_crc_error_i),
        .mask_wr_i    (write_interrupt_mask_i),
        .mask_dat_i   (internal_data_bus_i[NUM_DRIVES-1:0]),
        .clr_wr_i     (write_interrupt_clear_i),
        .clr_dat_i    (internal_data_bus_i[NUM_DRIVES-1:0]),
        .pending_o    (irq_pending),
        .interrupt_o  (interrupt_o)
    );

    assign interrupt_pending_o = 8'(irq_pending);

endmodule

// File: tb/tb_kfmmc_multi_drive_mux.sv
// Purpose: randomized and directed bench comparing the mux against a queue-based reference model.
// Latency: the model predicts combinational outputs each cycle, then advances on the edge.
// Backpressure: not applicable.
module tb_kfmmc_multi_drive_mux;

    localparam int N = 2;

    logic           clock_i = 1'b0;
    logic           reset_i;
    logic [7:0]     internal_data_bus_i;
    logic           write_drive_select_i, write_access_command_i;
    logic           write_block_address_1_i, write_block_address_2_i;
    logic           write_block_address_3_i, write_block_address_4_i;
    logic           write_data_i, read_data_i;
    logic           write_interrupt_mask_i, write_interrupt_clear_i;
    logic [7:0]     read_data_byte_o, status_o, interrupt_pending_o;
    logic           interrupt_o;
    logic [7:0]     drv_data_bus_o;
    logic [N-1:0]   drv_write_block_address_1_o, drv_write_block_address_2_o;
    logic [N-1:0]   drv_write_block_address_3_o, drv_write_block_address_4_o;
    logic [N-1:0]   drv_write_access_command_o, drv_write_data_o, drv_read_data_o;
    logic [8*N-1:0] drv_read_data_byte_i;
    logic [N-1:0]   drv_busy_i, drv_read_interface_error_i, drv_read_crc_error_i;
    logic [N-1:0]   drv_block_read_interrupt_i, drv_read_completion_interrupt_i;

    always #5 clock_i = ~clock_i;

    kfmmc_multi_drive_mux #(.NUM_DRIVES(N)) dut (
        .clock_i                         (clock_i),
        .reset_i                         (reset_i),
        .internal_data_bus_i             (internal_data_bus_i),
        .write_drive_select_i            (write_drive_select_i),
        .write_block_address_1_i         (write_block_address_1_i),
        .write_block_address_2_i         (write_block_address_2_i),
        .write_block_address_3_i         (write_block_address_3_i),
        .write_block_address_4_i         (write_block_address_4_i),
        .write_access_command_i          (write_access_command_i),
        .write_data_i                    (write_data_i),
        .read_data_i                     (read_data_i),
        .write_interrupt_mask_i          (write_interrupt_mask_i),
        .write_interrupt_clear_i         (write_interrupt_clear_i),
        .read_data_byte_o                (read_data_byte_o),
        .status_o                        (status_o),
        .interrupt_pending_o             (interrupt_pending_o),
        .interrupt_o                     (interrupt_o),
        .drv_data_bus_o                  (drv_data_bus_o),
        .drv_write_block_address_1_o     (drv_write_block_address_1_o),
        .drv_write_block_address_2_o     (drv_write_block_address_2_o),
        .drv_write_block_address_3_o     (drv_write_block_address_3_o),
        .drv_write_block_address_4_o     (drv_write_block_address_4_o),
        .drv_write_access_command_o      (drv_write_access_command_o),
        .drv_write_data_o                (drv_write_data_o),
        .drv_read_data_o                 (drv_read_data_o),
        .drv_read_data_byte_i            (drv_read_data_byte_i),
        .drv_busy_i                      (drv_busy_i),
        .drv_read_interface_error_i      (drv_read_interface_error_i),
        .drv_read_crc_error_i            (drv_read_crc_error_i),
        .drv_block_read_interrupt_i      (drv_block_read_interrupt_i),
        .drv_read_completion_interrupt_i (drv_read_completion_interrupt_i)
    );

    // Reference model: a future-strobe queue stands in for the burst sequencer.
    typedef struct {
        int         kind;   // 0..3 address byte index, 4 command
        int         drv;
        logic [7:0] dat;
    } ev_t;

    ev_t          m_q[$];
    int           m_sel, m_pend_sel;
    logic [7:0]   m_shadow [4];
    logic [7:0]   m_mask;
    logic [N-1:0] m_pending, m_prev_err;
    logic         m_rej, m_irq;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]   o_bus, o_status, o_pend;
    logic         o_irq;
    logic [N-1:0] o_wa [4];
    logic [N-1:0] o_wc;

    logic [7:0]   exp_b [5];
    int           busy_cnt, stray, cmd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int d);
        return N'(1) << d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sel = 0; m_pend_sel = -1;
        for (int k = 0; k < 4; k++) m_shadow[k] = 8'h00;
        m_mask = 8'hFF; m_pending = '0; m_prev_err = '0;
        m_rej = 1'b0; m_irq = 1'b0;
    endtask

    task automatic clear_inputs();
        reset_i = 1'b0;
        write_drive_select_i = 0; write_access_command_i = 0;
        write_block_address_1_i = 0; write_block_address_2_i = 0;
        write_block_address_3_i = 0; write_block_address_4_i = 0;
        write_data_i = 0; read_data_i = 0;
        write_interrupt_mask_i = 0; write_interrupt_clear_i = 0;
        drv_block_read_interrupt_i = '0; drv_read_completion_interrupt_i = '0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, release strobes.
    task automatic step();
        logic [N-1:0] e_wa [4];
        logic [N-1:0] e_wc, e_wd, e_rd, err, clr;
        logic [7:0]   e_bus, e_stat, bus;
        logic         busy, acc, irq_nx;
        ev_t          ev;
        @(negedge clock_i);
        bus  = internal_data_bus_i;
        busy = (m_q.size() != 0);
        for (int k = 0; k < 4; k++) e_wa[k] = '0;
        e_wc = '0; e_wd = '0; e_rd = '0; e_bus = bus;
        if (!reset_i) begin
            if (busy) begin
                ev = m_q[0];
                if (ev.kind < 4) e_wa[ev.kind] = oh(ev.drv);
                else             e_wc = oh(ev.drv);
                e_bus = ev.dat;
            end else begin
                if (write_data_i) e_wd = oh(m_sel);
                if (read_data_i)  e_rd = oh(m_sel);
            end
        end
        e_stat = {(|drv_busy_i) | busy, m_rej, busy, 1'b0, 4'(m_sel)};

        o_bus = drv_data_bus_o; o_status = status_o; o_pend = interrupt_pending_o;
        o_irq = interrupt_o;    o_wc = drv_write_access_command_o;
        o_wa[0] = drv_write_block_address_1_o; o_wa[1] = drv_write_block_address_2_o;
        o_wa[2] = drv_write_block_address_3_o; o_wa[3] = drv_write_block_address_4_o;

        chk("drv_bus", o_bus, e_bus);
        chk("addr_stb", {o_wa[0], o_wa[1], o_wa[2], o_wa[3]}, {e_wa[0], e_wa[1], e_wa[2], e_wa[3]});
        chk("cmd_stb", o_wc, e_wc);
        chk("wr_stb", drv_write_data_o, e_wd);
        chk("rd_stb", drv_read_data_o, e_rd);
        chk("rd_byte", read_data_byte_o, drv_read_data_byte_i[8*m_sel +: 8]);
        chk("status", o_status, e_stat);
        chk("pending", o_pend, 8'(m_pending));
        chk("interrupt", o_irq, m_irq);

        if (reset_i) begin
            model_reset();
        end else begin
            err    = drv_read_interface_error_i | drv_read_crc_error_i;
            irq_nx = |(m_pending & ~m_mask[N-1:0]);
            clr    = write_interrupt_clear_i ? bus[N-1:0] : '0;
            m_pending  = (m_pending & ~clr) | drv_block_read_interrupt_i
                       | drv_read_completion_interrupt_i | (err & ~m_prev_err);
            m_prev_err = err;
            if (write_interrupt_mask_i) m_mask = bus;
            m_irq = irq_nx;

            acc = write_access_command_i && !busy && !drv_busy_i[m_sel];
            if (write_interrupt_clear_i && bus[7]) m_rej = 1'b0;
            if (acc) m_rej = 1'b0;
            if (write_access_command_i && !acc) m_rej = 1'b1;
            if ((write_data_i || read_data_i) && busy) m_rej = 1'b1;

            if (busy) void'(m_q.pop_front());
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    ev.kind = k; ev.drv = m_sel; ev.dat = m_shadow[k];
                    m_q.push_back(ev);
                end
                ev.kind = 4; ev.drv = m_sel; ev.dat = bus;
                m_q.push_back(ev);
            end
            if (write_block_address_1_i) m_shadow[0] = bus;
            if (write_block_address_2_i) m_shadow[1] = bus;
            if (write_block_address_3_i) m_shadow[2] = bus;
            if (write_block_address_4_i) m_shadow[3] = bus;
            if (write_drive_select_i && int'(bus) < N) begin
                if (busy) m_pend_sel = int'(bus);
                else      m_sel = int'(bus);
            end
            if (m_q.size() == 0 && m_pend_sel >= 0) begin
                m_sel = m_pend_sel; m_pend_sel = -1;
            end
        end
        @(posedge clock_i);
        #1;
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        internal_data_bus_i = 8'h00;
        drv_read_data_byte_i = 16'hA55A;
        drv_busy_i = '0; drv_read_interface_error_i = '0; drv_read_crc_error_i = '0;
        repeat (2) @(posedge clock_i);
        #1;
        model_reset();
        reset_i = 1'b0;

        // Reset state
        step();
        chk("rst_status", o_status, 8'h00);
        chk("rst_pending", o_pend, 8'h00);
        chk("rst_irq", o_irq, 1'b0);

        // Address 12 34 56 78, command 11, committed to drive 1
        internal_data_bus_i = 8'h12; write_block_address_1_i = 1; step();
        internal_data_bus_i = 8'h34; write_block_address_2_i = 1; step();
        internal_data_bus_i = 8'h56; write_block_address_3_i = 1; step();
        internal_data_bus_i = 8'h78; write_block_address_4_i = 1; step();
        internal_data_bus_i = 8'h01; write_drive_select_i = 1;    step();
        internal_data_bus_i = 8'h11; write_access_command_i = 1;  step();
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h11};
        busy_cnt = 0; stray = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (o_status[5]) busy_cnt++;
            if (o_wa[0][0] | o_wa[1][0] | o_wa[2][0] | o_wa[3][0] | o_wc[0]) stray++;
            if (i < 5) begin
                chk("t2_bus", o_bus, exp_b[i]);
                if (i < 4) chk("t2_addr_stb", o_wa[i], 2'b10);
                else       chk("t2_cmd_stb", o_wc, 2'b10);
            end
        end
        chk("t2_busy_cycles", busy_cnt, 5);
        chk("t2_drive0_quiet", stray, 0);

        // Command rejected while the selected drive is busy
        drv_busy_i = 2'b01;
        internal_data_bus_i = 8'h00; write_drive_select_i = 1;   step();
        internal_data_bus_i = 8'h55; write_access_command_i = 1; step();
        step();
        chk("t3_rejected", o_status[6], 1'b1);
        chk("t3_no_cmd", o_wa[0] | o_wc, 2'b00);
        drv_busy_i = 2'b00;
        internal_data_bus_i = 8'h22; write_access_command_i = 1; step();
        step();
        chk("t3_rej_cleared", o_status[6], 1'b0);
        repeat (5) step();

        // Select written in burst cycle 2 is deferred until the burst ends
        internal_data_bus_i = 8'h33; write_access_command_i = 1; step();
        step();
        internal_data_bus_i = 8'h01; write_drive_select_i = 1;   step();
        step(); step(); step();
        chk("t4_sel_during", o_status[3:0], 4'h0);
        chk("t4_cmd_drive0", o_wc, 2'b01);
        step();
        chk("t4_sel_after", o_status[3:0], 4'h1);

        // Out-of-range select is ignored
        internal_data_bus_i = 8'h05; write_drive_select_i = 1; step();
        step();
        chk("t5_sel_hold", o_status[3:0], 4'h1);

        // Interrupts with mask FE
        internal_data_bus_i = 8'hFE; write_interrupt_mask_i = 1; step();
        drv_block_read_interrupt_i = 2'b01; step();
        step();
        chk("t6_pending", o_pend, 8'h01);
        step();
        chk("t6_irq", o_irq, 1'b1);
        internal_data_bus_i = 8'h01; write_interrupt_clear_i = 1;
        drv_block_read_interrupt_i = 2'b01; step();
        step();
        chk("t6_set_wins", o_pend, 8'h01);
        internal_data_bus_i = 8'h01; write_interrupt_clear_i = 1; step();
        step();
        chk("t6_cleared", o_pend, 8'h00);

        // Reset during A3
        internal_data_bus_i = 8'h44; write_access_command_i = 1; step();
        step(); step();
        cmd_seen = 0;
        reset_i = 1'b1; step();
        if (o_wc != '0) cmd_seen++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_wc != '0) cmd_seen++;
        end
        chk("t7_no_cmd", cmd_seen, 0);
        chk("t7_status", o_status, 8'h00);
        chk("t7_pending", o_pend, 8'h00);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int op;
            op = $urandom_range(0, 15);
            internal_data_bus_i = 8'($urandom);
            case (op)
                1: begin write_drive_select_i = 1; internal_data_bus_i = 8'($urandom_range(0, 4)); end
                2: write_block_address_1_i = 1;
                3: write_block_address_2_i = 1;
                4: write_block_address_3_i = 1;
                5: write_block_address_4_i = 1;
                6, 7: write_access_command_i = 1;
                8: write_data_i = 1;
                9: read_data_i = 1;
                10: write_interrupt_mask_i = 1;
                11: write_interrupt_clear_i = 1;
                default: ;
            endcase
            drv_busy_i = N'($urandom) & N'($urandom);
            drv_read_data_byte_i = (8*N)'($urandom);
            for (int d = 0; d < N; d++) begin
                drv_block_read_interrupt_i[d]      = ($urandom_range(0, 15) == 0);
                drv_read_completion_interrupt_i[d] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) drv_read_interface_error_i[d] = ~drv_read_interface_error_i[d];
                if ($urandom_range(0, 9) == 0) drv_read_crc_error_i[d] = ~drv_read_crc_error_i[d];
            end
            reset_i = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
